// File: rtl/fetch_sequencer_if.sv
// Bundle of every fetch_sequencer signal except clock and reset.
// Latency: none, wiring only.
// Backpressure: carried by mem_rdy (memory side) and instr_ack (decoder side).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface fetch_sequencer_if #(
   parameter int DATA_WIDTH = `DATA_WIDTH
);
   localparam int ADDR_WIDTH = 2 * DATA_WIDTH;

   // memory read side
   logic                  halt;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_rdy;
   logic                  mem_rd;

   // program-counter control
   logic                  pc_cs;
   logic                  pc_oe_a;
   logic                  pc_cnt_en;
   logic                  pc_we_l;
   logic                  pc_we_h;

   // shared data bus used to reload the PC
   logic [DATA_WIDTH-1:0] bus_out;
   logic                  bus_oe;

   // decoder handshake
   logic [DATA_WIDTH-1:0] ir;
   logic [ADDR_WIDTH-1:0] operand;
   logic                  instr_valid;
   logic                  instr_ack;
   logic                  jump_req;
   logic [ADDR_WIDTH-1:0] jump_addr;

   // sequencer side
   modport master (
      input  halt, mem_data, mem_rdy, instr_ack, jump_req, jump_addr,
      output mem_rd, pc_cs, pc_oe_a, pc_cnt_en, pc_we_l, pc_we_h,
             bus_out, bus_oe, ir, operand, instr_valid
   );

   // memory / PC / decoder side
   modport slave (
      output halt, mem_data, mem_rdy, instr_ack, jump_req, jump_addr,
      input  mem_rd, pc_cs, pc_oe_a, pc_cnt_en, pc_we_l, pc_we_h,
             bus_out, bus_oe, ir, operand, instr_valid
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch: reads opcode + 0..2 operand bytes at the PC, hands them to the decoder, reloads PC on jumps.
// Latency: one cycle per byte once mem_rdy is high; instr_valid rises the cycle after the last byte capture.
// Backpressure: read states stall while mem_rdy=0; HOLD stalls until instr_ack; halt blocks new opcode fetches.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fetch_sequencer #(
   parameter int DATA_WIDTH = `DATA_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.master fs
);
   localparam int ADDR_WIDTH = 2 * DATA_WIDTH;

   localparam logic [2:0] FETCH_OP = 3'd0;
   localparam logic [2:0] FETCH_LO = 3'd1;
   localparam logic [2:0] FETCH_HI = 3'd2;
   localparam logic [2:0] HOLD     = 3'd3;
   localparam logic [2:0] JUMP_L   = 3'd4;
   localparam logic [2:0] JUMP_H   = 3'd5;

   logic [2:0]            state;
   logic [2:0]            state_nxt;
   logic [DATA_WIDTH-1:0] ir_q;
   logic [ADDR_WIDTH-1:0] operand_q;
   logic [ADDR_WIDTH-1:0] target_q;
   logic                  valid_q;

   logic                  rd_active;
   logic                  byte_take;
   logic                  load_l;
   logic                  load_h;

   // Strobe decode; everything is forced low while reset is held so the PC
   // and bus see a quiet controller for the whole reset window.
   always_comb begin
      rd_active = 1'b0;
      case (state)
         FETCH_OP: rd_active = !fs.halt;
         FETCH_LO: rd_active = 1'b1;
         FETCH_HI: rd_active = 1'b1;
         default:  rd_active = 1'b0;
      endcase
      rd_active = rd_active && !reset;
      byte_take = rd_active && fs.mem_rdy;
      load_l    = (state == JUMP_L) && !reset;
      load_h    = (state == JUMP_H) && !reset;
   end

   assign fs.mem_rd      = rd_active;
   assign fs.pc_oe_a     = rd_active;
   assign fs.pc_cnt_en   = byte_take;
   assign fs.pc_we_l     = load_l;
   assign fs.pc_we_h     = load_h;
   assign fs.pc_cs       = rd_active | load_l | load_h;
   assign fs.bus_oe      = load_l | load_h;
   assign fs.bus_out     = load_l ? target_q[DATA_WIDTH-1:0] :
                           load_h ? target_q[ADDR_WIDTH-1:DATA_WIDTH] : '0;
   assign fs.ir          = ir_q;
   assign fs.operand     = operand_q;
   assign fs.instr_valid = valid_q;

   // Next-state: operand count comes from the opcode byte on the bus in
   // FETCH_OP (it is not registered yet) and from ir_q afterwards.
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH_OP: if (byte_take)
                      state_nxt = (fs.mem_data[DATA_WIDTH-1:DATA_WIDTH-2] == 2'b00) ? HOLD : FETCH_LO;
         FETCH_LO: if (byte_take)
                      state_nxt = (ir_q[DATA_WIDTH-1:DATA_WIDTH-2] == 2'b01) ? HOLD : FETCH_HI;
         FETCH_HI: if (byte_take)
                      state_nxt = HOLD;
         HOLD:     if (fs.instr_ack)
                      state_nxt = fs.jump_req ? JUMP_L : FETCH_OP;
         JUMP_L:   state_nxt = JUMP_H;
         JUMP_H:   state_nxt = FETCH_OP;
         default:  state_nxt = FETCH_OP;
      endcase
   end

   // State register and registered valid, which is high exactly while in HOLD.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH_OP;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_q <= (state_nxt == HOLD);
      end
   end

   // Byte capture and jump-target latch; reset drops any partial instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q      <= '0;
         operand_q <= '0;
         target_q  <= '0;
      end else begin
         if (byte_take) begin
            case (state)
               FETCH_OP: begin
                  ir_q      <= fs.mem_data;
                  operand_q <= '0;
               end
               FETCH_LO: operand_q[DATA_WIDTH-1:0]          <= fs.mem_data;
               FETCH_HI: operand_q[ADDR_WIDTH-1:DATA_WIDTH] <= fs.mem_data;
               default:  ;
            endcase
         end
         if ((state == HOLD) && fs.instr_ack && fs.jump_req)
            target_q <= fs.jump_addr;
      end
   end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller sitting directly downstream of the program-counter register.
- Drives the PC address onto the memory bus, reads opcode plus 0-2 operand bytes, and steps the PC via its count enable.
- Presents the assembled instruction to the decoder with a valid/ack handshake.
- On a taken jump, reloads the PC low then high byte over the shared data bus before refetching.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (8), width of opcode, operand bytes and data bus.
- ADDR_WIDTH, 2*DATA_WIDTH, PC/jump address width.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- halt  input  1  when high, no new fetch is started
- mem_data  input  DATA_WIDTH  byte returned by memory
- mem_rdy  input  1  memory read data valid this cycle
- mem_rd  output  1  memory read request
- pc_cs  output  1  PC chip select
- pc_oe_a  output  1  PC drives address bus
- pc_cnt_en  output  1  PC increment enable
- pc_we_l  output  1  PC low-byte load
- pc_we_h  output  1  PC high-byte load
- bus_out  output  DATA_WIDTH  value driven onto shared data bus
- bus_oe  output  1  bus_out valid/driving
- ir  output  DATA_WIDTH  fetched opcode
- operand  output  ADDR_WIDTH  operand bytes {hi,lo}; unused bytes zero
- instr_valid  output  1  ir/operand complete and stable
- instr_ack  input  1  decoder consumed instruction
- jump_req  input  1  with instr_ack: take jump
- jump_addr  input  ADDR_WIDTH  jump target

Behaviour:
- Reset: state=FETCH_OP. All outputs 0 (ir=0, operand=0, instr_valid=0, every strobe 0). Reset overrides every state, including mid-read and mid-jump; a partially fetched instruction is discarded.
- Operand count n = ir[DATA_WIDTH-1:DATA_WIDTH-2]: 00→0, 01→1, 10→2, 11→2.
- States: FETCH_OP, FETCH_LO, FETCH_HI, HOLD, JUMP_L, JUMP_H.
- Read states (FETCH_OP/LO/HI):
  - mem_rd=pc_cs=pc_oe_a=1 combinationally every cycle in state. FETCH_OP asserts these only when halt=0.
  - Waits indefinitely while mem_rdy=0.
  - On the cycle mem_rdy=1: pc_cnt_en=1 (PC increments at that edge) and the byte is captured at the same edge.
- FETCH_OP:
  - Captures ir and clears operand.
  - Next state: n=0→HOLD, else FETCH_LO.
  - With halt=1, stays in FETCH_OP with no strobes.
- FETCH_LO: captures operand[DATA_WIDTH-1:0]. Next: n=1→HOLD, else FETCH_HI.
- FETCH_HI: captures operand[ADDR_WIDTH-1:DATA_WIDTH], then HOLD.
- Valid timing: instr_valid is registered, 1 in HOLD only. It rises the cycle after the final byte capture.
- HOLD:
  - ir/operand stable. Waits for instr_ack.
  - instr_ack=1, jump_req=0 → FETCH_OP; instr_valid drops next cycle.
  - instr_ack=1, jump_req=1 → latch jump_addr internally, go to JUMP_L.
  - jump_req without instr_ack is ignored.
- JUMP_L (one cycle): pc_cs=1, pc_we_l=1, bus_oe=1, bus_out=target[7:0]; mem_rd=0, pc_oe_a=0, pc_cnt_en=0.
- JUMP_H (one cycle): pc_cs=1, pc_we_h=1, bus_oe=1, bus_out=target[15:8]; then FETCH_OP.
- Mutual exclusion: pc_cnt_en and pc_we_* are never asserted together. bus_oe=0 in every other state.
- Wrap-around: PC wrap FFFF→0000 is the PC's concern; the fetch continues normally across it.
- Throughput: minimum 2 cycles per 1-byte instruction (FETCH_OP + HOLD) with mem_rdy tied high and immediate ack.

Test Plan:
- Reset, then mem_rdy=1, mem_data=0x05 (n=0), instr_ack high on first valid → 1 pc_cnt_en pulse; ir=0x05, operand=0x0000, instr_valid high exactly 1 cycle, 2 cycles after reset release.
- Fetch opcode 0x80 then bytes 0x34, 0x12 with mem_rdy delayed 2 cycles per byte → exactly 3 pc_cnt_en pulses; operand=0x1234, ir=0x80; no strobes during wait cycles.
- Opcode 0x41 then 0xAB → operand=0x00AB; opcode 0xC0 behaves as n=2.
- In HOLD, instr_ack=1, jump_req=1, jump_addr=0xBEEF → next cycle pc_we_l=1 with bus_out=0xEF, then pc_we_h=1 with bus_out=0xBE, then FETCH_OP read; no pc_cnt_en during jump.
- jump_req=1 with instr_ack=0 in HOLD for 5 cycles → no state change, instr_valid stays 1. halt=1 in FETCH_OP → mem_rd stays 0 until halt drops.
- Assert reset during FETCH_HI and during JUMP_L → next cycle all outputs 0, state FETCH_OP, no pc_we_*/bus_oe asserted.
